// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM->WB stage handshake and payload bundle
//
// Groups the M-side inputs (ValidM, payload, ReadyM back-pressure) and the
// W-side outputs (ValidW, head-entry payload, ReadyW, RetireCount).
//   slave  : the stage itself (consumes M-side, produces W-side)
//   master : the surrounding pipeline / testbench
interface mem_wb_stage_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int RESULT_SRC_WIDTH = 2,
    parameter int RETIRE_WIDTH     = 32
);
    logic                        ValidM;
    logic                        ReadyM;
    logic                        RegWriteM;
    logic [RESULT_SRC_WIDTH-1:0] ResultSrcM;
    logic [DATA_WIDTH-1:0]       ALUResultM;
    logic [DATA_WIDTH-1:0]       ReadData;
    logic [REG_ADDR_WIDTH-1:0]   RdM;
    logic [DATA_WIDTH-1:0]       PCPlus4M;

    logic                        ValidW;
    logic                        ReadyW;
    logic                        RegWriteW;
    logic [RESULT_SRC_WIDTH-1:0] ResultSrcW;
    logic [DATA_WIDTH-1:0]       ALUResultW;
    logic [DATA_WIDTH-1:0]       ReadDataW;
    logic [REG_ADDR_WIDTH-1:0]   RdW;
    logic [DATA_WIDTH-1:0]       PCPlus4W;
    logic [RETIRE_WIDTH-1:0]     RetireCount;

    modport slave (
        input  ValidM, RegWriteM, ResultSrcM, ALUResultM, ReadData, RdM, PCPlus4M, ReadyW,
        output ReadyM, ValidW, RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W,
               RetireCount
    );

    modport master (
        output ValidM, RegWriteM, ResultSrcM, ALUResultM, ReadData, RdM, PCPlus4M, ReadyW,
        input  ReadyM, ValidW, RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W,
               RetireCount
    );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - elastic MEM->WB pipeline register with skid buffer
//
// Ports:
//   clk   : clock, all state changes on posedge
//   rst   : asynchronous active-low reset
//   flush : synchronous kill of both held entries (payload kept)
//   bus   : mem_wb_stage_if.slave - M-side inputs, W-side outputs, RetireCount
//
// Two entries: "main" drives the W outputs, "skid" catches one extra
// instruction while main is stalled. ReadyM is simply the inverse of the skid
// valid flop, so it never depends combinationally on ReadyW.
module mem_wb_stage #(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int RESULT_SRC_WIDTH = 2,
    parameter int RETIRE_WIDTH     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    mem_wb_stage_if.slave bus
);
    localparam int PW = 1 + RESULT_SRC_WIDTH + 3 * DATA_WIDTH + REG_ADDR_WIDTH;

    logic [PW-1:0]           in_payload;
    logic [PW-1:0]           main_q, main_d;
    logic [PW-1:0]           skid_q, skid_d;
    logic                    main_valid_q, main_valid_d;
    logic                    skid_valid_q, skid_valid_d;
    logic [RETIRE_WIDTH-1:0] retire_q;
    logic                    main_regwrite;
    logic                    accept;
    logic                    consume;

    assign in_payload = {bus.RegWriteM, bus.ResultSrcM, bus.ALUResultM,
                         bus.ReadData, bus.RdM, bus.PCPlus4M};

    assign bus.ReadyM = ~skid_valid_q;
    assign accept     = bus.ValidM & ~skid_valid_q;
    assign consume    = main_valid_q & bus.ReadyW;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // Payload is left untouched; only the valid bits are killed.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume && skid_valid_q) begin
            // ReadyM is low here, so no accept can coincide with this case.
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end else if (consume) begin
            if (accept) begin
                main_d = in_payload;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_d       = in_payload;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = in_payload;
                main_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // A consume in a flush cycle still retires the head instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_q <= '0;
        end else if (consume) begin
            retire_q <= retire_q + RETIRE_WIDTH'(1);
        end
    end

    assign {main_regwrite, bus.ResultSrcW, bus.ALUResultW,
            bus.ReadDataW, bus.RdW, bus.PCPlus4W} = main_q;

    assign bus.ValidW      = main_valid_q;
    assign bus.RegWriteW   = main_regwrite & main_valid_q;
    assign bus.RetireCount = retire_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - testbench for mem_wb_stage
module tb_mem_wb_stage;
    localparam int DW = 32;
    localparam int RA = 5;
    localparam int RS = 2;
    localparam int RW = 4;

    logic clk;
    logic rst;
    logic flush;

    mem_wb_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RA), .RESULT_SRC_WIDTH(RS),
                      .RETIRE_WIDTH(RW)) bus ();

    mem_wb_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RA), .RESULT_SRC_WIDTH(RS),
                   .RETIRE_WIDTH(RW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an in-order queue of at most two instructions plus a retire tally.
    typedef struct {
        logic          rw;
        logic [RS-1:0] rs;
        logic [DW-1:0] alu;
        logic [DW-1:0] rdata;
        logic [RA-1:0] rd;
        logic [DW-1:0] pc;
    } ent_t;

    ent_t mq[$];
    int   m_ret = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_ret = 0;
        end else begin
            bit   acc;
            bit   con;
            ent_t e;
            acc = bus.ValidM && (mq.size() < 2);
            con = (mq.size() > 0) && bus.ReadyW;
            e.rw = bus.RegWriteM;
            e.rs = bus.ResultSrcM;
            e.alu = bus.ALUResultM;
            e.rdata = bus.ReadData;
            e.rd = bus.RdM;
            e.pc = bus.PCPlus4M;
            if (con) m_ret = (m_ret + 1) % (1 << RW);
            if (flush) begin
                mq.delete();
            end else begin
                if (con) void'(mq.pop_front());
                if (acc) mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("ReadyM", 32'(bus.ReadyM), 32'(mq.size() < 2));
            chk("ValidW", 32'(bus.ValidW), 32'(mq.size() > 0));
            chk("RetireCount", 32'(bus.RetireCount), 32'(m_ret));
            if (mq.size() > 0) begin
                chk("RegWriteW", 32'(bus.RegWriteW), 32'(mq[0].rw));
                chk("ResultSrcW", 32'(bus.ResultSrcW), 32'(mq[0].rs));
                chk("ALUResultW", bus.ALUResultW, mq[0].alu);
                chk("ReadDataW", bus.ReadDataW, mq[0].rdata);
                chk("RdW", 32'(bus.RdW), 32'(mq[0].rd));
                chk("PCPlus4W", bus.PCPlus4W, mq[0].pc);
            end else begin
                chk("RegWriteW_idle", 32'(bus.RegWriteW), 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic rw, input logic [RA-1:0] rd,
                          input logic [DW-1:0] alu);
        bus.ValidM     = v;
        bus.RegWriteM  = rw;
        bus.RdM        = rd;
        bus.ResultSrcM = rd[1:0];
        bus.ALUResultM = alu;
        bus.ReadData   = alu ^ 32'hA5A5_0000;
        bus.PCPlus4M   = alu + 32'd4;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        bus.ReadyW = 1'b0;
        set_in(1'b0, 1'b0, '0, '0);
        cyc();
        check_en = 1'b1;
        chk("reset_ReadyM", 32'(bus.ReadyM), 32'd1);
        chk("reset_ValidW", 32'(bus.ValidW), 32'd0);
        chk("reset_Retire", 32'(bus.RetireCount), 32'd0);
        chk("reset_ALUResultW", bus.ALUResultW, 32'd0);
        rst = 1'b1;
        cyc();

        // Back-to-back stream
        bus.ReadyW = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b1, RA'(i + 1), 32'(16 * (i + 1)));
            cyc();
            chk("stream_alu", bus.ALUResultW, 32'(16 * (i + 1)));
            chk("stream_ready", 32'(bus.ReadyM), 32'd1);
        end
        set_in(1'b0, 1'b0, '0, '0);
        cyc();
        chk("stream_retire", 32'(bus.RetireCount), 32'd4);
        chk("stream_empty", 32'(bus.ValidW), 32'd0);

        // Backpressure into the skid entry
        bus.ReadyW = 1'b0;
        set_in(1'b1, 1'b1, 5'd5, 32'h55);
        cyc();
        set_in(1'b1, 1'b0, 5'd6, 32'h66);
        cyc();
        set_in(1'b0, 1'b0, '0, '0);
        chk("bp_rd5", 32'(bus.RdW), 32'd5);
        chk("bp_readym", 32'(bus.ReadyM), 32'd0);
        cyc();
        chk("bp_hold", 32'(bus.RdW), 32'd5);
        bus.ReadyW = 1'b1;
        cyc();
        chk("bp_rd6", 32'(bus.RdW), 32'd6);
        chk("bp_ready_back", 32'(bus.ReadyM), 32'd1);
        cyc();
        chk("bp_drained", 32'(bus.ValidW), 32'd0);
        chk("bp_retire", 32'(bus.RetireCount), 32'd6);

        // Flush with both entries full and a new input offered
        bus.ReadyW = 1'b0;
        set_in(1'b1, 1'b1, 5'd7, 32'h77);
        cyc();
        set_in(1'b1, 1'b1, 5'd8, 32'h88);
        cyc();
        set_in(1'b1, 1'b1, 5'd9, 32'h99);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        set_in(1'b0, 1'b0, '0, '0);
        chk("flush_validw", 32'(bus.ValidW), 32'd0);
        chk("flush_regwrite", 32'(bus.RegWriteW), 32'd0);
        chk("flush_readym", 32'(bus.ReadyM), 32'd1);
        chk("flush_retire", 32'(bus.RetireCount), 32'd6);

        // Consume in a flush cycle still retires
        set_in(1'b1, 1'b0, 5'd10, 32'hA0);
        cyc();
        set_in(1'b0, 1'b0, '0, '0);
        bus.ReadyW = 1'b1;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flushcon_retire", 32'(bus.RetireCount), 32'd7);

        // RegWriteW gated by ValidW
        bus.ReadyW = 1'b0;
        set_in(1'b1, 1'b1, 5'd11, 32'hB0);
        cyc();
        set_in(1'b0, 1'b0, '0, '0);
        chk("gate_on", 32'(bus.RegWriteW), 32'd1);
        bus.ReadyW = 1'b1;
        cyc();
        chk("gate_off", 32'(bus.RegWriteW), 32'd0);
        chk("gate_retire", 32'(bus.RetireCount), 32'd8);

        // Counter wrap: 17 consumes from reset
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        bus.ReadyW = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_in(1'b1, 1'(i), RA'(i), 32'(i * 3 + 1));
            cyc();
        end
        set_in(1'b0, 1'b0, '0, '0);
        cyc();
        chk("wrap_retire", 32'(bus.RetireCount), 32'd1);

        // Mixed traffic against the model
        for (int i = 0; i < 150; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom), RA'($urandom),
                   32'($urandom));
            bus.ReadyW = 1'($urandom_range(0, 2) != 0);
            flush = 1'($urandom_range(0, 15) == 0);
            cyc();
        end
        flush = 1'b0;

        // Asynchronous reset while stalled with a full skid
        bus.ReadyW = 1'b0;
        set_in(1'b1, 1'b1, 5'd12, 32'hC0);
        cyc();
        set_in(1'b1, 1'b1, 5'd13, 32'hD0);
        cyc();
        set_in(1'b0, 1'b0, '0, '0);
        cyc();
        chk("async_pre_readym", 32'(bus.ReadyM), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_validw", 32'(bus.ValidW), 32'd0);
        chk("async_retire", 32'(bus.RetireCount), 32'd0);
        chk("async_regwrite", 32'(bus.RegWriteW), 32'd0);
        chk("async_readym", 32'(bus.ReadyM), 32'd1);
        cyc();
        rst = 1'b1;
        cyc();
        cyc();

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised MEM→WB boundary register for the pipelined RV32I core. Generalises the plain flop stage.
- Carries RegWrite, ResultSrc, ALU result, read data, rd index and PC+4 from the Memory stage to Writeback.
- Adds a valid/ready elastic handshake with a 2-entry skid buffer, a synchronous flush, and a retired-instruction counter.
- Sits between the data memory / M-stage logic and the writeback mux / register file.

Parameters:
- DATA_WIDTH, 32, width of ALUResult, ReadData, PCPlus4.
- REG_ADDR_WIDTH, 5, width of destination register index.
- RESULT_SRC_WIDTH, 2, width of ResultSrc select.
- RETIRE_WIDTH, 32, width of retired-instruction counter.

Ports:
- clk, input, 1: single clock; all state updates on posedge clk.
- rst, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous kill of all held entries.
- ValidM, input, 1: M-stage holds a valid instruction.
- ReadyM, output, 1: stage can accept this cycle.
- RegWriteM, input, 1: register write enable.
- ResultSrcM, input, RESULT_SRC_WIDTH: writeback select.
- ALUResultM, input, DATA_WIDTH: ALU result.
- ReadData, input, DATA_WIDTH: data memory read value.
- RdM, input, REG_ADDR_WIDTH: destination register.
- PCPlus4M, input, DATA_WIDTH: PC+4 for jal/jalr.
- ValidW, output, 1: W outputs hold a valid instruction.
- ReadyW, input, 1: writeback consumes this cycle.
- RegWriteW, output, 1: RegWrite of head entry, gated by ValidW.
- ResultSrcW, output, RESULT_SRC_WIDTH: head entry field.
- ALUResultW, output, DATA_WIDTH: head entry field.
- ReadDataW, output, DATA_WIDTH: head entry field.
- RdW, output, REG_ADDR_WIDTH: head entry field.
- PCPlus4W, output, DATA_WIDTH: head entry field.
- RetireCount, output, RETIRE_WIDTH: instructions retired since reset.

Behaviour:
- Storage: main entry (drives W outputs) and skid entry, each with its own valid bit.
- Reset (rst low, asynchronous):
  - Both valid bits cleared; all payload registers cleared to 0; RetireCount = 0.
  - Consequently ValidW = 0, RegWriteW = 0, ReadyM = 1.
- Handshakes:
  - ReadyM = ~skid_valid, registered, with no combinational path from ReadyW.
  - Accept = ValidM & ReadyM.
  - Consume = ValidW & ReadyW.
- Latency: an accepted instruction appears on W outputs the next cycle when main is empty or being consumed and skid is empty.
- Next-state cases when flush = 0:
  - Accept, with main empty or consume, and skid empty: main ← input.
  - Accept, main valid, no consume: skid ← input; ReadyM drops next cycle.
  - Consume with skid valid: main ← skid; skid_valid ← 0. If accept happens in the same cycle (possible only when the skid was empty before), that case is covered above.
  - Consume, skid empty, no accept: main_valid ← 0.
  - Order is strictly preserved; no entry is dropped or duplicated.
- RegWriteW = main.RegWrite & main_valid. An invalid entry never writes the register file.
- Flush (synchronous, highest priority):
  - Clears main_valid and skid_valid at the next edge.
  - An input presented in the same cycle is discarded.
  - A consume in the flush cycle still counts as retired.
  - Payload registers are not cleared.
- RetireCount increments by 1 on every consume. It wraps from 2^RETIRE_WIDTH−1 to 0 and holds otherwise.
- Reset asserted mid-operation: immediate clear as above, regardless of clk. Deassertion takes effect at the next edge.

Test Plan:
- Reset then stream: ReadyW=1, 4 back-to-back accepts (ALUResultM=0x10,0x20,0x30,0x40) → ALUResultW follows one cycle later, ValidW high 4 cycles, ReadyM stays 1, RetireCount=4.
- Backpressure: ReadyW=0 with two accepts (Rd=5 then Rd=6) → ValidW=1 with RdW=5 held, ReadyM=0 after the 2nd accept. Raise ReadyW → RdW=5 then RdW=6 on consecutive cycles, ReadyM returns to 1.
- Flush with full skid: two entries held, flush=1 with ValidM=1 → next cycle ValidW=0, RegWriteW=0, ReadyM=1, RetireCount unchanged.
- Gated write: entry with RegWriteM=1 consumed, then idle → RegWriteW=1 only while ValidW=1, and 0 afterwards even though the payload register holds 1.
- Wrap: RETIRE_WIDTH=4, 17 consumes → RetireCount=1.
- Async reset mid-stall: skid full, drive rst low between edges → ValidW, RetireCount and RegWriteW go to 0 immediately, ReadyM=1.
